// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and helpers for the matrix keypad scanner
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } kp_state_e;

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic int key_code(input int row, input int col, input int cols);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// rtl/keypad_col_scan.sv - free-running column counter with one-hot-low column drive
module keypad_col_scan #(
   parameter int COLS = 4
) (
   input  logic                    scan_clk,
   input  logic                    rst,
   output logic [COLS-1:0]         col_n,
   output logic [$clog2(COLS)-1:0] col_idx
);

   localparam int CW = $clog2(COLS);

   logic [CW-1:0] col_q;
   logic [CW-1:0] col_d;

   always_comb begin
      col_d = col_q + 1'b1;
      if (col_q == CW'(COLS - 1)) begin
         col_d = '0;
      end
   end

   always_ff @(posedge scan_clk) begin
      if (rst) begin
         col_q <= '0;
      end else begin
         col_q <= col_d;
      end
   end

   assign col_n   = ~({{(COLS-1){1'b0}}, 1'b1} << col_q);
   assign col_idx = col_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - debounced matrix keypad scanner with valid/ready key events
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int DEBOUNCE = 3,
   parameter int KEY_W    = $clog2(ROWS * COLS)
) (
   input  logic             scan_clk,
   input  logic             rst,
   input  logic [ROWS-1:0]  row_n,
   output logic [COLS-1:0]  col_n,
   output logic             keydown,
   output logic [KEY_W-1:0] key,
   output logic             key_valid,
   input  logic             key_ready,
   output logic             overflow
);

   localparam int CW = $clog2(COLS);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CNT_W-1:0] DB_CNT = CNT_W'(DEBOUNCE);

   kp_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RW-1:0]    trk_row_q, trk_row_d;
   logic [CW-1:0]    trk_col_q, trk_col_d;
   logic             keydown_q, keydown_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             key_valid_q, key_valid_d;
   logic             overflow_q, overflow_d;

   logic [CW-1:0]    col_idx;
   logic [RW-1:0]    low_row;
   logic             any_low;
   logic             trk_hit;
   logic             trk_low;
   logic             press;
   logic [CNT_W-1:0] cnt_inc;

   keypad_col_scan #(
      .COLS (COLS)
   ) u_col_scan (
      .scan_clk (scan_clk),
      .rst      (rst),
      .col_n    (col_n),
      .col_idx  (col_idx)
   );

   // Descending loop so the lowest-index low row wins.
   always_comb begin
      low_row = '0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (!row_n[r]) begin
            low_row = RW'(r);
         end
      end
   end

   assign any_low = ~&row_n;
   assign trk_hit = (col_idx == trk_col_q);
   assign trk_low = ~row_n[trk_row_q];
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      trk_row_d   = trk_row_q;
      trk_col_d   = trk_col_q;
      keydown_d   = keydown_q;
      key_d       = key_q;
      key_valid_d = key_valid_q & ~key_ready;
      overflow_d  = overflow_q;
      press       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (any_low) begin
               trk_row_d = low_row;
               trk_col_d = col_idx;
               cnt_d     = 4'd1;
               if (DB_CNT == 4'd1) begin
                  state_d = HELD;
                  press   = 1'b1;
               end else begin
                  state_d = PRESS_DB;
               end
            end
         end
         PRESS_DB: begin
            if (trk_hit) begin
               if (trk_low) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= DB_CNT) begin
                     state_d = HELD;
                     press   = 1'b1;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
         end
         HELD: begin
            if (trk_hit && !trk_low) begin
               cnt_d = 4'd1;
               if (DB_CNT == 4'd1) begin
                  keydown_d = 1'b0;
                  state_d   = IDLE;
               end else begin
                  state_d = RELEASE_DB;
               end
            end
         end
         RELEASE_DB: begin
            if (trk_hit) begin
               if (!trk_low) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= DB_CNT) begin
                     keydown_d = 1'b0;
                     state_d   = IDLE;
                  end
               end else begin
                  state_d = HELD;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // An event still pending after this edge's consumption means the new press is lost.
      if (press) begin
         keydown_d = 1'b1;
         if (key_valid_d) begin
            overflow_d = 1'b1;
         end else begin
            key_valid_d = 1'b1;
            key_d       = KEY_W'(key_code(int'(trk_row_d), int'(trk_col_d), COLS));
         end
      end
   end

   always_ff @(posedge scan_clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         trk_row_q   <= '0;
         trk_col_q   <= '0;
         keydown_q   <= 1'b0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         trk_row_q   <= trk_row_d;
         trk_col_q   <= trk_col_d;
         keydown_q   <= keydown_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign keydown   = keydown_q;
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign overflow  = overflow_q;

endmodule
